// File: rtl/serial_pkg.sv
// serial_pkg: shared constants and state encoding for the serial link blocks
package serial_pkg;
    localparam int SER_WIDTH = 4;
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;
endpackage

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel-in, one-bit-per-clock serial-out transmitter
module piso_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    state_t state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic last, accept;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            sreg  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sreg  <= sreg_nxt;
        end
    end
    // outputs decode registered state only; load_valid feeds next-state logic alone
    always_comb begin
        last         = (state == ST_SHIFT) && (cnt == '0);
        load_ready   = (state == ST_IDLE) || last;
        accept       = load_valid && load_ready;
        serial_valid = (state == ST_SHIFT);
        done         = last;
        serial_out   = serial_valid & (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);
        state_nxt    = accept ? ST_SHIFT : (last ? ST_IDLE : state);
        cnt_nxt      = accept ? CW'(WIDTH-1) : ((state == ST_SHIFT && !last) ? cnt - 1'b1 : cnt);
        sreg_nxt     = accept ? data_in : ((state == ST_SHIFT) ? (MSB_FIRST ? sreg << 1 : sreg >> 1) : sreg);
    end
endmodule
